// File: rtl/hart_idle_ctrl.sv
// Hart idle controller: PAUSE spin-wait timer and CEASE drain-then-power-down sequencer.
// Every output is a register written in the single state-machine process.
module hart_idle_ctrl #(
  parameter int unsigned PAUSE_CYCLES = 32,
  parameter int unsigned DRAIN_QUIET  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pause_req,
  input  logic       cease_req,
  input  logic       id_mem_busy,
  input  logic       interrupt_pending,
  input  logic       debug_halt,
  output logic       id_reg_pause,
  output logic       cease,
  output logic       id_stall,
  output logic [7:0] pause_count
);

  typedef enum logic [1:0] {RUN, PAUSE, DRAIN, CEASED} state_t;

  localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_CYCLES - 1);
  localparam logic [3:0] QUIET_LAST = 4'(DRAIN_QUIET - 1);

  state_t     state;
  logic [3:0] quiet_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      id_reg_pause <= 1'b0;
      cease        <= 1'b0;
      id_stall     <= 1'b0;
      pause_count  <= '0;
      quiet_cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cease_req) begin
            state     <= DRAIN;
            id_stall  <= 1'b1;
            quiet_cnt <= '0;
          end else if (pause_req) begin
            state        <= PAUSE;
            id_reg_pause <= 1'b1;
            id_stall     <= 1'b1;
            pause_count  <= PAUSE_LOAD;
          end
        end
        PAUSE: begin
          // cease outranks wake-up and expiry; id_stall stays high into DRAIN
          if (cease_req) begin
            state        <= DRAIN;
            id_reg_pause <= 1'b0;
            pause_count  <= '0;
            quiet_cnt    <= '0;
          end else if (interrupt_pending || debug_halt || pause_count == '0) begin
            state        <= RUN;
            id_reg_pause <= 1'b0;
            id_stall     <= 1'b0;
            pause_count  <= '0;
          end else begin
            pause_count <= pause_count - 8'd1;
          end
        end
        DRAIN: begin
          if (id_mem_busy) begin
            quiet_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + 4'd1;
            // the quiet cycle that completes the run moves to CEASED directly
            if (quiet_cnt == QUIET_LAST) begin
              state <= CEASED;
              cease <= 1'b1;
            end
          end
        end
        CEASED: begin
          state <= CEASED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/hart_idle_ctrl.md
HART_IDLE_CTRL -- requirements
Module: hart_idle_ctrl

Interface
REQ-001 The block SHALL have parameter PAUSE_CYCLES, default 32, meaning the number of cycles a PAUSE hint holds the hart, legal range 1..255.
REQ-002 The block SHALL have parameter DRAIN_QUIET, default 4, meaning the consecutive memory-idle cycles required before cease, legal range 1..15.
REQ-003 The block SHALL have port clock  input  1  the single clock for all state.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port pause_req  input  1  one-cycle pulse: a PAUSE instruction issued from ID.
REQ-006 The block SHALL have port cease_req  input  1  one-cycle pulse: a CEASE instruction retired.
REQ-007 The block SHALL have port id_mem_busy  input  1  an older memory op is outstanding ahead of ID.
REQ-008 The block SHALL have port interrupt_pending  input  1  an enabled interrupt is pending.
REQ-009 The block SHALL have port debug_halt  input  1  a debug halt request.
REQ-010 The block SHALL have port id_reg_pause  output  1  the hart is paused for spin-wait idling.
REQ-011 The block SHALL have port cease  output  1  safe to power down; no further retirement until reset.
REQ-012 The block SHALL have port id_stall  output  1  hold the ID stage.
REQ-013 The block SHALL have port pause_count  output  8  remaining pause cycles.

Function
REQ-014 The block SHALL implement FSM states RUN, PAUSE, DRAIN, CEASED, with all outputs registered.
REQ-015 In RUN, cease_req SHALL move the FSM to DRAIN, and cease_req SHALL take priority over a same-cycle pause_req.
REQ-016 In RUN, pause_req alone SHALL move the FSM to PAUSE and load pause_count with PAUSE_CYCLES-1.
REQ-017 id_reg_pause SHALL be 1 for exactly PAUSE_CYCLES cycles, starting the cycle after pause_req, unless exited early.
REQ-018 In PAUSE, pause_count SHALL decrement by 1 per cycle.
REQ-019 In PAUSE, the FSM SHALL return to RUN on the cycle after pause_count==0 is observed; pause_count SHALL never wrap below 0.
REQ-020 In PAUSE, interrupt_pending or debug_halt SHALL exit to RUN; id_reg_pause=0 and pause_count=0 SHALL hold the next cycle.
REQ-021 In PAUSE, pause_req SHALL be ignored: no reload, no extension.
REQ-022 In PAUSE, cease_req SHALL move the FSM to DRAIN, taking priority over a same-cycle interrupt or expiry.
REQ-023 In DRAIN, a 4-bit quiet counter SHALL increment each cycle id_mem_busy==0 and clear to 0 each cycle id_mem_busy==1.
REQ-024 When the quiet counter reaches DRAIN_QUIET, the FSM SHALL move to CEASED, with cease=1 on the following cycle.
REQ-025 In DRAIN, interrupt_pending, debug_halt, pause_req and cease_req SHALL be ignored.
REQ-026 In DRAIN, id_reg_pause SHALL be 0.
REQ-027 CEASED SHALL be terminal until reset, with cease=1 and id_stall=1 held and all inputs ignored.
REQ-028 id_stall SHALL be 1 whenever the state is PAUSE, DRAIN or CEASED, and 0 in RUN.
REQ-029 id_stall SHALL be asserted in the same cycle id_reg_pause rises.
REQ-030 cease SHALL never be 1 unless id_mem_busy was 0 for DRAIN_QUIET consecutive cycles immediately before.

Reset
REQ-031 Asserting reset low SHALL immediately force state=RUN, id_reg_pause=0, cease=0, id_stall=0, pause_count=0 and quiet counter=0, independent of clock.
REQ-032 Reset SHALL be the only exit from CEASED.
REQ-033 Reset asserted mid-PAUSE or mid-DRAIN SHALL abandon the operation with no residual state.
REQ-034 Deassertion of reset SHALL be treated as synchronous to clock.
REQ-035 The first pause_req honoured after reset SHALL be one in the cycle after reset deasserts.

Verification
REQ-036 Pause expiry: PAUSE_CYCLES=32, pause_req pulse at cycle 10 -> id_reg_pause=1 for cycles 11..42, pause_count 31 at cycle 11 and 0 at cycle 42, RUN at cycle 43.
REQ-037 Early exit: pause at cycle 10, interrupt_pending=1 at cycle 15 -> id_reg_pause=0 and id_stall=0 at cycle 16.
REQ-038 Drain with busy: cease_req at cycle 5, id_mem_busy=1 for cycles 6..9 then 0, DRAIN_QUIET=4 -> cease=1 at cycle 14 and remains 1.
REQ-039 Busy glitch: in DRAIN, id_mem_busy pattern 0,0,0,1,0,0,0,0 -> the quiet count restarts and cease asserts only after the final four zeros.
REQ-040 Priority: cease_req and pause_req in the same cycle -> DRAIN with id_reg_pause never 1; cease_req during PAUSE together with interrupt_pending -> DRAIN.
REQ-041 Reset in CEASED: reset low asynchronously mid-cycle -> cease=0 and id_stall=0 immediately; a subsequent pause_req is honoured.
